// File: rtl/sub_result_if.sv
// Handshake and data bundle between subtractor32bit and its registered result stage.
// master drives operands, results and out_ready; slave is the stage itself.
interface sub_result_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     sub_in0;
  logic [WIDTH-1:0]     sub_in1;
  logic [WIDTH-1:0]     sub_out;
  logic                 sub_borrow;
  logic                 clr_count;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_result;
  logic                 out_borrow;
  logic                 out_zero;
  logic                 out_neg;
  logic                 out_ovf;
  logic [CNT_WIDTH-1:0] borrow_count;

  modport master (
    output in_valid, sub_in0, sub_in1, sub_out, sub_borrow, clr_count, out_ready,
    input  in_ready, out_valid, out_result, out_borrow, out_zero, out_neg, out_ovf,
           borrow_count
  );

  modport slave (
    input  in_valid, sub_in0, sub_in1, sub_out, sub_borrow, clr_count, out_ready,
    output in_ready, out_valid, out_result, out_borrow, out_zero, out_neg, out_ovf,
           borrow_count
  );
endinterface

// File: rtl/sub_result_stage.sv
// Registered result/flag stage behind subtractor32bit with a 2-entry skid buffer.
// One-cycle latency when empty; in_ready is a registered decode of state, independent of out_ready.
module sub_result_stage #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input logic          clk,
  input logic          rst_n,
  sub_result_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             borrow;
    logic             zero;
    logic             neg;
    logic             ovf;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t               state, state_nxt;
  entry_t               main_q, main_nxt;
  entry_t               skid_q, skid_nxt;
  entry_t               in_entry;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_nxt;
  logic                 accept;
  logic                 pop;
  logic                 unused_bits;

  assign accept = bus.in_valid & in_ready_q;
  assign pop    = out_valid_q & bus.out_ready;

  // Only the operand sign bits matter for signed overflow.
  assign unused_bits = ^{bus.sub_in0[WIDTH-2:0], bus.sub_in1[WIDTH-2:0]};

  always_comb begin
    in_entry        = '0;
    in_entry.result = bus.sub_out;
    in_entry.borrow = bus.sub_borrow;
    in_entry.zero   = ~|bus.sub_out;
    in_entry.neg    = bus.sub_out[WIDTH-1];
    in_entry.ovf    = (bus.sub_in0[WIDTH-1] ^ bus.sub_in1[WIDTH-1]) &
                      (bus.sub_in0[WIDTH-1] ^ bus.sub_out[WIDTH-1]);
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state)
      EMPTY: begin
        if (accept) begin
          main_nxt  = in_entry;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_nxt = in_entry;
        end else if (accept) begin
          skid_nxt  = in_entry;
          state_nxt = FULL;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_nxt  = skid_q;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Clear wins over a same-cycle increment; increment stops at all-ones.
  always_comb begin
    cnt_nxt = cnt_q;
    if (bus.clr_count) begin
      cnt_nxt = '0;
    end else if (accept && bus.sub_borrow && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_nxt = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state       <= state_nxt;
      main_q      <= main_nxt;
      skid_q      <= skid_nxt;
      in_ready_q  <= (state_nxt != FULL);
      out_valid_q <= (state_nxt != EMPTY);
      cnt_q       <= cnt_nxt;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = main_q.result;
  assign bus.out_borrow   = main_q.borrow;
  assign bus.out_zero     = main_q.zero;
  assign bus.out_neg      = main_q.neg;
  assign bus.out_ovf      = main_q.ovf;
  assign bus.borrow_count = cnt_q;

endmodule
